// File: rtl/polling_scheduler.sv
// Round-robin poll launcher: each period tick issues one req/ack poll to the next enabled channel.
// Latency: tick to poll_req is 1 cycle; ack to poll_done is 1 cycle; all outputs registered.
// Backpressure: a request is held until acked (or aged out); ticks arriving meanwhile are dropped and flagged.
//
// Optional feature: define POLL_TIMEOUT_EN to abandon a request after TIMEOUT_CYCLES un-acked cycles.
//
// Ports:
//   clock, reset       core clock (posedge), asynchronous active-low reset
//   enable             scheduler run control; low clears the tick counter
//   period             cycles between ticks (0 behaves as 1)
//   channel_mask       per-channel eligibility
//   poll_ack           per-channel acknowledge; only the active channel's bit is observed
//   poll_req           one-hot request, held until ack/timeout
//   active_channel     index of the requested channel (meaningful while busy)
//   busy               high while a request is outstanding
//   poll_done          1-cycle pulse after an acked poll
//   missed_tick        1-cycle pulse for a tick that landed while busy
//   poll_timeout       1-cycle pulse for an abandoned request (constant 0 without POLL_TIMEOUT_EN)
module polling_scheduler #(
    parameter int NUM_CHANNELS   = 4,
    parameter int PERIOD_W       = 16,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [PERIOD_W-1:0]     period,
    input  logic [NUM_CHANNELS-1:0] channel_mask,
    input  logic [NUM_CHANNELS-1:0] poll_ack,
    output logic [NUM_CHANNELS-1:0] poll_req,
    output logic [CH_W-1:0]         active_channel,
    output logic                    busy,
    output logic                    poll_done,
    output logic                    missed_tick,
    output logic                    poll_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_REQ  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] period_m1;
    logic                tick;

    logic [CH_W-1:0]     ptr;
    logic [CH_W-1:0]     sel;
    logic                any_elig;
    logic                ack_hit;
    logic                age_exp;
    logic                start;
    logic                fin_ack;
    logic                fin_to;

    // ------------------------------------------------------------------
    // Tick generator. The >= compare means a period shrunk below the
    // current count fires on the very next cycle instead of wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        period_m1 = (period == '0) ? '0 : period - 1'b1;
        tick      = enable && (cnt >= period_m1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first eligible channel strictly after ptr,
    // wrapping. Scanning offsets from largest to smallest lets the
    // nearest one overwrite; offset NUM_CHANNELS lands back on ptr itself.
    // ------------------------------------------------------------------
    always_comb begin
        int          idx;
        logic [CH_W-1:0] idx_c;
        sel   = ptr;
        idx   = 0;
        idx_c = '0;
        for (int i = NUM_CHANNELS; i >= 1; i--) begin
            idx   = (int'(ptr) + i) % NUM_CHANNELS;
            idx_c = CH_W'(idx);
            if (channel_mask[idx_c]) begin
                sel = idx_c;
            end
        end
    end

    assign any_elig = |channel_mask;
    assign ack_hit  = poll_ack[active_channel];

    // ------------------------------------------------------------------
    // Request age (optional abandon path)
    // ------------------------------------------------------------------
`ifdef POLL_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [AGE_W-1:0] age;

    assign age_exp = (age == AGE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            age <= '0;
        end else if (start) begin
            age <= '0;
        end else if (state == S_REQ) begin
            age <= age + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            poll_timeout <= 1'b0;
        end else begin
            poll_timeout <= fin_to;
        end
    end
`else
    assign age_exp      = 1'b0;
    assign poll_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IDLE and WAIT both launch on a tick; tick already implies enable,
    // so an IDLE block that just got enabled never loses its first tick.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        fin_ack   = 1'b0;
        fin_to    = 1'b0;
        case (state)
            S_IDLE, S_WAIT: begin
                if (tick && any_elig) begin
                    state_nxt = S_REQ;
                    start     = 1'b1;
                end else if (enable) begin
                    state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                // An ack on the expiry cycle takes priority over the abandon.
                if (ack_hit) begin
                    fin_ack   = 1'b1;
                    state_nxt = enable ? S_WAIT : S_IDLE;
                end else if (age_exp) begin
                    fin_to    = 1'b1;
                    state_nxt = enable ? S_WAIT : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_REQ);

    // ------------------------------------------------------------------
    // Registered outputs and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            poll_req       <= '0;
            active_channel <= '0;
            ptr            <= CH_W'(NUM_CHANNELS - 1);
            poll_done      <= 1'b0;
            missed_tick    <= 1'b0;
        end else begin
            poll_done   <= fin_ack;
            missed_tick <= (state == S_REQ) && tick;
            if (start) begin
                poll_req       <= NUM_CHANNELS'(1) << sel;
                active_channel <= sel;
                ptr            <= sel;
            end else if (fin_ack || fin_to) begin
                poll_req <= '0;
            end
        end
    end

endmodule

// File: tb/tb_polling_scheduler.sv
module tb_polling_scheduler;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int PW = 16;
    localparam int TO = 64;
`ifdef POLL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] period = '0;
    logic [N-1:0]  channel_mask = '0;
    logic [N-1:0]  poll_ack = '0;
    logic [N-1:0]  poll_req;
    logic [CW-1:0] active_channel;
    logic          busy;
    logic          poll_done;
    logic          missed_tick;
    logic          poll_timeout;

    polling_scheduler #(
        .NUM_CHANNELS  (N),
        .PERIOD_W      (PW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .period        (period),
        .channel_mask  (channel_mask),
        .poll_ack      (poll_ack),
        .poll_req      (poll_req),
        .active_channel(active_channel),
        .busy          (busy),
        .poll_done     (poll_done),
        .missed_tick   (missed_tick),
        .poll_timeout  (poll_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            cyc;
        logic [N-1:0]  req;
        logic          bsy;
        logic [CW-1:0] ch;
        logic          done;
        logic          missed;
        logic          tmo;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model state (plain integers, spec-level rules)
    int m_cnt  = 0;
    int m_ptr  = N - 1;
    int m_ch   = 0;
    int m_age  = 0;
    bit m_busy = 1'b0;

    int missed_total = 0;
    int tmo_total    = 0;

    function automatic int next_sel(input int p, input logic [N-1:0] m);
        for (int i = 1; i <= N; i++) begin
            if (m[(p + i) % N]) return (p + i) % N;
        end
        return p;
    endfunction

    // Model: each edge, derive what the outputs must show right after it.
    always @(posedge clock) begin : model
        int   eff;
        bit   tk, dn, ms, tm;
        exp_t e;
        cyc++;
        if (!reset) begin
            m_cnt  = 0;
            m_ptr  = N - 1;
            m_busy = 1'b0;
            m_age  = 0;
        end else begin
            eff   = (period == 0) ? 1 : int'(period);
            tk    = enable && (m_cnt >= eff - 1);
            m_cnt = (!enable || tk) ? 0 : m_cnt + 1;
            dn = 1'b0; ms = 1'b0; tm = 1'b0;
            if (m_busy) begin
                ms = tk;
                if (poll_ack[m_ch]) begin
                    m_busy = 1'b0;
                    dn     = 1'b1;
                end else if (TO_EN && m_age == TO - 1) begin
                    m_busy = 1'b0;
                    tm     = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (tk && channel_mask != 0) begin
                m_ch   = next_sel(m_ptr, channel_mask);
                m_ptr  = m_ch;
                m_busy = 1'b1;
                m_age  = 0;
            end
            if (m_busy || dn || ms || tm) begin
                e.cyc    = cyc;
                e.req    = m_busy ? (N'(1) << m_ch) : '0;
                e.bsy    = m_busy;
                e.ch     = CW'(m_ch);
                e.done   = dn;
                e.missed = ms;
                e.tmo    = tm;
                sb.push_back(e);
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT shows activity.
    always @(negedge clock) begin : monitor
        exp_t e;
        bit   act;
        if (reset) begin
            if (missed_tick) missed_total++;
            if (poll_timeout) tmo_total++;
            act = (poll_req != '0) || busy || poll_done || missed_tick || poll_timeout;
            if (act) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d got req=%b busy=%b done=%b missed=%b tmo=%b, required no activity",
                             cyc, poll_req, busy, poll_done, missed_tick, poll_timeout);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || poll_req !== e.req || busy !== e.bsy ||
                        (e.bsy && active_channel !== e.ch) || poll_done !== e.done ||
                        missed_tick !== e.missed || poll_timeout !== e.tmo) begin
                        errors++;
                        $display("FAIL sb_compare cyc=%0d got req=%b busy=%b ch=%0d done=%b missed=%b tmo=%b required cyc=%0d req=%b busy=%b ch=%0d done=%b missed=%b tmo=%b",
                                 cyc, poll_req, busy, active_channel, poll_done, missed_tick, poll_timeout,
                                 e.cyc, e.req, e.bsy, e.ch, e.done, e.missed, e.tmo);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                checks++;
                errors++;
                e = sb.pop_front();
                $display("FAIL missing_output cyc=%0d got no activity required req=%b busy=%b done=%b missed=%b tmo=%b",
                         cyc, e.req, e.bsy, e.done, e.missed, e.tmo);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int ack_delay = 0;
    int req_age   = 0;
    bit ack_on    = 1'b1;
    bit noise     = 1'b0;

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (poll_req != '0) begin
            req_age++;
            poll_ack = (ack_on && req_age > ack_delay) ? poll_req : '0;
        end else begin
            req_age  = 0;
            poll_ack = '0;
        end
        if (noise) poll_ack = poll_ack | (N'($urandom) & ~poll_req);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        sb.delete();
        #1;
        chk({tag, "_req"},    int'(poll_req), 0);
        chk({tag, "_busy"},   int'(busy), 0);
        chk({tag, "_done"},   int'(poll_done), 0);
        chk({tag, "_missed"}, int'(missed_tick), 0);
        chk({tag, "_tmo"},    int'(poll_timeout), 0);
        chk({tag, "_ch"},     int'(active_channel), 0);
        run(2);
        reset = 1'b1;
    endtask

    task automatic wait_req(output logic [N-1:0] r);
        int k;
        k = 0;
        while (poll_req == '0 && k < 200) begin
            step();
            k++;
        end
        if (poll_req == '0) begin
            checks++;
            errors++;
            $display("FAIL wait_req_start got no request required a request within 200 cycles");
        end
        r = poll_req;
        k = 0;
        while (poll_req != '0 && k < 200) begin
            step();
            k++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no completion required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] seq1 [5];
        logic [N-1:0] seq2 [3];
        int           base, k;
        seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq2 = '{4'b0010, 4'b1000, 4'b0010};

        // Reset state
        run(2);
        do_reset("rst0");

        // Full mask, ack one cycle after each request
        period = 16'd5; channel_mask = 4'b1111; enable = 1'b1; ack_delay = 0;
        for (int i = 0; i < 5; i++) begin
            wait_req(r);
            chk($sformatf("ph1_poll%0d", i), int'(r), int'(seq1[i]));
        end

        // Sparse mask from fresh pointer, then empty mask
        enable = 1'b0;
        do_reset("rst1");
        channel_mask = 4'b1010; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_req(r);
            chk($sformatf("ph2_poll%0d", i), int'(r), int'(seq2[i]));
        end
        channel_mask = 4'b0000;
        run(20);
        chk("ph2_empty_busy", int'(busy), 0);

        // Slow ack: ticks during the request are missed
        channel_mask = 4'b1111; period = 16'd3; ack_delay = 7;
        wait_req(r);
        k = 0;
        while (poll_req == '0 && k < 20) begin step(); k++; end
        base = missed_total;
        while (poll_req != '0 && k < 60) begin step(); k++; end
        chk("ph3_missed", missed_total - base, 2);
        run(12);

        // Period shrink below current count, then period 0
        ack_delay = 0; period = 16'd100;
        k = 0;
        while (m_cnt != 50 && k < 400) begin step(); k++; end
        chk("ph4_reach50", m_cnt, 50);
        period = 16'd4;
        step();
        chk("ph4_shrink_tick", int'(poll_req != '0), 1);
        run(20);
        period = 16'd0;
        run(20);

        // Disable mid-request, then reset mid-request
        period = 16'd4; ack_delay = 5;
        k = 0;
        while (poll_req == '0 && k < 20) begin step(); k++; end
        enable = 1'b0;
        k = 0;
        while (poll_req != '0 && k < 20) begin step(); k++; end
        run(20);
        chk("ph5_disabled_busy", int'(busy), 0);
        enable = 1'b1;
        k = 0;
        while (poll_req == '0 && k < 20) begin step(); k++; end
        do_reset("rst_midreq");
        run(10);

        // No acks at all: timeout build abandons, default build holds
        period = 16'd10; ack_on = 1'b0;
        base = tmo_total;
        run(220);
        chk("ph6_timeout_seen", int'(tmo_total > base), int'(TO_EN));
        ack_on = 1'b1;
        run(20);

        // Randomized traffic with ack noise on idle channels
        noise = 1'b1;
        for (int i = 0; i < 40; i++) begin
            period       = PW'($urandom_range(0, 7));
            channel_mask = N'($urandom);
            enable       = ($urandom_range(0, 9) != 0);
            ack_delay    = $urandom_range(0, 6);
            run(20);
        end
        noise = 1'b0;
        enable = 1'b1;
        run(20);
        enable = 1'b0;
        run(20);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
